// File: rtl/l2_pkg.sv
// Shared types and sizing constants for the L2 physical-memory adapter.
package l2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } pmem_state_t;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = 4;
  localparam int TIMEOUT_MAX = 1023;

endpackage

// File: rtl/l2_beat_shifter.sv
// Beat select / beat insert for a 256-bit line split into four 64-bit beats.
// sel_line[k] drives beat_out; line_out is ins_line with beat k replaced.
module l2_beat_shifter
  import l2_pkg::*;
(
  input  logic [LINE_W-1:0] sel_line,
  input  logic [LINE_W-1:0] ins_line,
  input  logic [1:0]        k,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [BEAT_W-1:0] beat_out,
  output logic [LINE_W-1:0] line_out
);

  logic [7:0] base;

  // Beat k sits at bit offset 64*k.
  always_comb begin
    base     = {k, 6'd0};
    beat_out = sel_line[base +: BEAT_W];
    line_out = ins_line;
    line_out[base +: BEAT_W] = beat_in;
  end

endmodule

// File: rtl/l2_pmem_adapter.sv
// L2 line <-> 4-beat memory burst adapter.
// Optional burst watchdog enabled by defining L2_PMEM_ADAPTER_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a line request; outputs quiet
// RD_BURST | read_o high, collecting four beats into line_o
// WR_BURST | write_o high, presenting four beats of the latched line
// DONE     | one-cycle resp_o pulse, then back to IDLE
module l2_pmem_adapter
  import l2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i,
  output logic              err_o
);

  pmem_state_t       state_q, state_d;
  logic [1:0]        beat_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wline_q;
  logic [LINE_W-1:0] rline_q;
  logic              take;
  logic [BEAT_W-1:0] sel_beat;
  logic [LINE_W-1:0] ins_line;

`ifdef L2_PMEM_ADAPTER_TIMEOUT_EN
  logic [9:0] tmo_q;
  logic       err_q;
  logic       timeout;
`endif

  l2_beat_shifter u_shift (
    .sel_line (wline_q),
    .ins_line (rline_q),
    .k        (beat_q),
    .beat_in  (burst_i),
    .beat_out (sel_beat),
    .line_out (ins_line)
  );

  // State register; async reset abandons any burst without a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and Moore-style outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    address_o = '0;
    burst_o   = '0;
    take      = 1'b0;
`ifdef L2_PMEM_ADAPTER_TIMEOUT_EN
    timeout   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (write_i)     state_d = WR_BURST;
        else if (read_i) state_d = RD_BURST;
      end
      RD_BURST: begin
        read_o    = 1'b1;
        address_o = addr_q;
        take      = resp_i;
        if (resp_i && beat_q == 2'd3) state_d = DONE;
      end
      WR_BURST: begin
        write_o   = 1'b1;
        address_o = addr_q;
        burst_o   = sel_beat;
        take      = resp_i;
        if (resp_i && beat_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef L2_PMEM_ADAPTER_TIMEOUT_EN
    // The stall that would bring the count to TIMEOUT_MAX aborts the burst.
    if ((state_q == RD_BURST || state_q == WR_BURST) && !resp_i &&
        tmo_q == 10'(TIMEOUT_MAX - 1)) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
`endif
  end

  // Request latches, beat counter and read-line assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      beat_q  <= '0;
    end else begin
      if (state_q == IDLE && (read_i || write_i)) begin
        addr_q <= address_i;
        beat_q <= '0;
        if (write_i) wline_q <= line_i;
      end
      if (take) begin
        beat_q <= beat_q + 2'd1;
        if (state_q == RD_BURST) rline_q <= ins_line;
      end
    end
  end

  assign line_o = rline_q;

`ifdef L2_PMEM_ADAPTER_TIMEOUT_EN
  // Stall watchdog: counts consecutive non-accepted burst cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == RD_BURST || state_q == WR_BURST) begin
      if (resp_i) begin
        tmo_q <= '0;
      end else if (timeout) begin
        tmo_q <= '0;
        err_q <= 1'b1;
      end else begin
        tmo_q <= tmo_q + 10'd1;
      end
    end else begin
      tmo_q <= '0;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_l2_pmem_adapter.sv
// Randomized self-checking bench for l2_pmem_adapter.
module tb_l2_pmem_adapter;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic         err_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [255:0] exp_line = '0;

  l2_pmem_adapter dut (
    .clk       (clk),
    .reset     (reset),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One full line transfer. For reads, data holds the four beats memory returns
  // (beat n in data[64n+:64]); for writes, data is the line handed to the adapter.
  task automatic run_xfer(input bit is_wr, input logic [31:0] addr, input logic [255:0] data,
                          input int stall_pct, input bit also_rd, input bit chk_lat);
    int cyc;
    int n;
    int guard;
    bit give;
    @(negedge clk);
    address_i = addr;
    line_i    = is_wr ? data : rand_line();
    write_i   = is_wr;
    read_i    = !is_wr || also_rd;
    @(negedge clk);
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = rand_line();
    address_i = $urandom;
    cyc = 2; n = 0; guard = 0;
    while (n < 4 && guard < 300) begin
      check_eq("read_o", read_o, !is_wr);
      check_eq("write_o", write_o, is_wr);
      check_eq("addr_burst", address_o, addr);
      check_eq("resp_mid", resp_o, 0);
      if (is_wr) check_eq("burst_o", burst_o, data[n*64 +: 64]);
      else       check_eq("burst_o_rd", burst_o, 0);
      give    = ($urandom_range(99) >= stall_pct);
      resp_i  = give;
      burst_i = (give && !is_wr) ? data[n*64 +: 64] : {$urandom, $urandom};
      read_i  = $urandom_range(1);
      write_i = $urandom_range(1);
      @(negedge clk);
      cyc++; guard++;
      if (give) n++;
    end
    if (guard >= 300) check_eq("burst_bound", 0, 1);
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = $urandom_range(1);
    burst_i = {$urandom, $urandom};
    if (!is_wr) exp_line = data;
    check_eq("resp_done", resp_o, 1);
    check_eq("read_o_done", read_o, 0);
    check_eq("write_o_done", write_o, 0);
    check_eq("burst_o_done", burst_o, 0);
    check_eq("line_o", line_o, exp_line);
    if (chk_lat) check_eq("latency", cyc, 6);
    @(negedge clk);
    resp_i = 1'b0;
    check_eq("resp_after", resp_o, 0);
    check_eq("addr_idle", address_o, 0);
    check_eq("line_o_idle", line_o, exp_line);
  endtask

  initial begin
    logic [255:0] d;
    reset = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    @(negedge clk);
    check_eq("rst_read_o", read_o, 0);
    check_eq("rst_write_o", write_o, 0);
    check_eq("rst_resp_o", resp_o, 0);
    check_eq("rst_err_o", err_o, 0);
    check_eq("rst_addr", address_o, 0);
    check_eq("rst_line", line_o, 0);
    check_eq("rst_burst", burst_o, 0);
    @(negedge clk);
    reset = 1'b0;

    // stray strobe in IDLE must not start anything
    resp_i = 1'b1; burst_i = 64'hdead;
    @(negedge clk);
    resp_i = 1'b0;
    check_eq("idle_resp_i", {read_o, write_o, resp_o}, 0);

    // directed read, back-to-back beats
    d = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    run_xfer(1'b0, 32'h0000_1240, d, 0, 1'b0, 1'b1);

    // directed write with stalls (random stall rate)
    run_xfer(1'b1, 32'h0000_2000,
             256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0, 50, 1'b0, 1'b0);
    // write back-to-back, latency
    run_xfer(1'b1, 32'h0000_2020, rand_line(), 0, 1'b0, 1'b1);
    // simultaneous read+write: write wins
    run_xfer(1'b1, 32'h0000_3000, rand_line(), 30, 1'b1, 1'b0);

    // reset after two read beats
    @(negedge clk);
    address_i = 32'h0000_4000; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    resp_i = 1'b0;
    check_eq("pre_rst_read_o", read_o, 1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_read_o", read_o, 0);
    check_eq("mid_rst_addr", address_o, 0);
    check_eq("mid_rst_line", line_o, 0);
    exp_line = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("no_resp_after_rst", resp_o, 0);
      @(negedge clk);
    end
    run_xfer(1'b0, 32'h0000_4000, rand_line(), 0, 1'b0, 1'b1);

    // random mix
    for (int t = 0; t < 24; t++) begin
      run_xfer($urandom_range(1), {$urandom_range(32'h07ff_ffff), 5'd0}, rand_line(),
               $urandom_range(70), $urandom_range(1), 1'b0);
    end

    // stall with resp_i held low
    @(negedge clk);
    address_i = 32'h0000_5000; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0; resp_i = 1'b0;
`ifdef L2_PMEM_ADAPTER_TIMEOUT_EN
    repeat (1022) @(negedge clk);
    check_eq("tmo_err_early", err_o, 0);
    check_eq("tmo_read_early", read_o, 1);
    @(negedge clk);
    check_eq("tmo_err", err_o, 1);
    check_eq("tmo_read_o", read_o, 0);
    check_eq("tmo_resp_o", resp_o, 0);
    @(negedge clk);
    check_eq("tmo_resp_o2", resp_o, 0);
    run_xfer(1'b0, 32'h0000_5020, rand_line(), 20, 1'b0, 1'b0);
    check_eq("tmo_sticky", err_o, 1);
`else
    repeat (1100) @(negedge clk);
    check_eq("no_tmo_err", err_o, 0);
    check_eq("no_tmo_read_o", read_o, 1);
    d = rand_line();
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = d[i*64 +: 64];
      @(negedge clk);
    end
    resp_i = 1'b0;
    check_eq("late_resp", resp_o, 1);
    check_eq("late_line", line_o, d);
    check_eq("late_err", err_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_pmem_adapter.md
L2_PMEM_ADAPTER -- requirements
Module: l2_pmem_adapter

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset, named clk and reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  async active-high reset
- line_i  in  256  line written to memory, from the L2 datapath pmem_wdata
- line_o  out  256  line read from memory, to the L2 datapath pmem_rdata
- address_i  in  32  32-byte-aligned line address, from the L2 datapath pmem_address
- read_i  in  1  line read request from the L2 control
- write_i  in  1  line write request from the L2 control
- resp_o  out  1  one-cycle line-done pulse to the L2 control
- burst_i  in  64  memory read beat
- burst_o  out  64  memory write beat
- address_o  out  32  address to memory
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  beat-valid/accepted strobe from memory
- err_o  out  1  sticky timeout flag

Function
REQ-003 SHALL implement the FSM states IDLE, RD_BURST, WR_BURST and DONE.
REQ-004 In IDLE with read_i=1, the FSM SHALL latch address_i, clear the beat counter and go to RD_BURST next cycle.
REQ-005 In IDLE with write_i=1, the FSM SHALL latch address_i and line_i, clear the beat counter and go to WR_BURST.
REQ-006 In IDLE, if read_i and write_i are both 1, write SHALL win.
REQ-007 Requests outside IDLE SHALL be ignored.
REQ-008 In RD_BURST, read_o SHALL be 1 and address_o SHALL equal the latched address, held until the fourth beat is taken.
REQ-009 In RD_BURST, each cycle with resp_i=1 SHALL store burst_i into line_o[64k+63:64k], where k is the 2-bit beat count, then increment k.
REQ-010 Beats in RD_BURST need not be consecutive; cycles with resp_i=0 SHALL hold k.
REQ-011 In WR_BURST, write_o SHALL be 1, address_o SHALL equal the latched address, and burst_o SHALL equal latched_line[64k+63:64k].
REQ-012 In WR_BURST, k SHALL advance on each cycle with resp_i=1.
REQ-013 When the beat with k=3 is taken, the FSM SHALL go to DONE, and read_o/write_o SHALL deassert that next cycle.
REQ-014 In DONE, resp_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-015 Minimum latency SHALL be 6 cycles from request to resp_o: 1 accept + 4 beats + 1 DONE.
REQ-016 line_o SHALL be stable from DONE until the next accepted read's first beat.
REQ-017 line_o SHALL be unaffected by writes.
REQ-018 resp_i outside RD_BURST/WR_BURST SHALL be ignored.
REQ-019 The beat counter SHALL be 2 bits; the beat-3 transition SHALL occur instead of wrap.
REQ-020 address_o SHALL be 0 in IDLE.
REQ-021 burst_o SHALL be 0 outside WR_BURST.

Reset
REQ-022 On reset, the FSM SHALL go to IDLE immediately and asynchronously, including mid-burst.
REQ-023 On reset: read_o=0, write_o=0, resp_o=0, err_o=0, address_o=0, beat counter=0, line_o=0, latched line/address=0.
REQ-024 An interrupted burst SHALL NOT produce resp_o.

Configuration
REQ-025 Macro L2_PMEM_ADAPTER_TIMEOUT_EN SHALL control the timeout feature.
REQ-026 With L2_PMEM_ADAPTER_TIMEOUT_EN defined:
- a 10-bit counter SHALL clear on each accepted beat and on entry to a burst state;
- it SHALL increment each burst-state cycle with resp_i=0;
- on reaching 1023, err_o SHALL set (sticky until reset) and the FSM SHALL go to IDLE without resp_o.
REQ-027 Without L2_PMEM_ADAPTER_TIMEOUT_EN, err_o SHALL be tied 0, no counter SHALL exist, and bursts SHALL wait indefinitely.

Structure
REQ-028 Package l2_pkg SHALL hold:
- typedef pmem_state_t (IDLE, RD_BURST, WR_BURST, DONE);
- constants LINE_W=256, BEAT_W=64, BEATS=4, TIMEOUT_MAX=1023.
REQ-029 A single sub-module l2_beat_shifter SHALL provide beat select/insert by k; FSM and latches SHALL stay in the top module.

Verification
REQ-030 Read, consecutive beats: read_i=1 at 0x0000_1240, resp_i=1 for 4 cycles with burst_i=0x11..,0x22..,0x33..,0x44.. -> line_o={0x44..,0x33..,0x22..,0x11..}, resp_o single pulse at cycle 6, address_o=0x0000_1240 during burst.
REQ-031 Write with stalls: line_i=256'h0123..., resp_i pattern 1,0,0,1,1,0,1 -> burst_o steps through line_i[63:0]..[255:192] only on resp_i=1, write_o drops after 4th accept, resp_o pulses once.
REQ-032 Simultaneous read_i=write_i=1 in IDLE -> write_o=1, read_o=0; read_i during WR_BURST ignored.
REQ-033 Reset asserted after 2 read beats -> read_o=0 same cycle, no resp_o; next read starts at beat 0 with correct line.
REQ-034 With L2_PMEM_ADAPTER_TIMEOUT_EN: read with resp_i held 0 -> err_o=1 after 1023 stalled cycles, FSM in IDLE, no resp_o. Without the macro: err_o stays 0 and read_o stays 1.
